// File: rtl/input_cmd_decoder.sv
// Strobed command-code decoder with press edge detection, move auto-repeat and flash divider.
// Optional build macro INPUT_CMD_SATURATE_EN: colour and speed steps saturate instead of wrapping.
module input_cmd_decoder #(
  parameter int CODE_W      = 4,
  parameter int COLOR_BITS  = 3,
  parameter int SPEED_W     = 4,
  parameter int SPEED_MIN   = 1,
  parameter int SPEED_MAX   = 4,
  parameter int REPEAT_DLY  = 16,
  parameter int REPEAT_RATE = 4,
  parameter int FLASH_DIV   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CODE_W-1:0]       inCode,
  input  logic                    inValid,
  output logic [2:0]              userNum,
  output logic [SPEED_W-1:0]      movSpeed,
  output logic [3*COLOR_BITS-1:0] charRGB,
  output logic [3*COLOR_BITS-1:0] bgRGB,
  output logic [3:0]              charOffset,
  output logic                    flashClk,
  output logic                    cmdAck
);

  localparam int RGB_W   = 3 * COLOR_BITS;
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rptState_t;

  rptState_t          rptState;
  logic [RPT_W-1:0]   rptCnt;
  logic [FLASH_W-1:0] flashCnt;
  logic               flashEn;
  logic               targetBg;
  logic               prevValid;
  logic [CODE_W-1:0]  prevCode;

  logic       press;
  logic       inRange;
  logic [3:0] op;

  assign press   = inValid && (!prevValid || (inCode != prevCode));
  assign inRange = (inCode >> 4) == '0;
  assign op      = inCode[3:0];

  function automatic logic [COLOR_BITS-1:0] incChan(input logic [COLOR_BITS-1:0] v);
`ifdef INPUT_CMD_SATURATE_EN
    return (&v) ? v : v + COLOR_BITS'(1);
`else
    return v + COLOR_BITS'(1);
`endif
  endfunction

  // ch selects the channel slot inside {R,G,B}: 2=R, 1=G, 0=B.
  function automatic logic [RGB_W-1:0] bumpRgb(input logic [RGB_W-1:0] rgb, input int ch);
    logic [RGB_W-1:0] res;
    res = rgb;
    res[ch*COLOR_BITS +: COLOR_BITS] = incChan(rgb[ch*COLOR_BITS +: COLOR_BITS]);
    return res;
  endfunction

  function automatic logic [SPEED_W-1:0] speedUp(input logic [SPEED_W-1:0] s);
    if (s == SPEED_W'(SPEED_MAX))
`ifdef INPUT_CMD_SATURATE_EN
      return SPEED_W'(SPEED_MAX);
`else
      return SPEED_W'(SPEED_MIN);
`endif
    return s + SPEED_W'(1);
  endfunction

  function automatic logic [SPEED_W-1:0] speedDown(input logic [SPEED_W-1:0] s);
    if (s == SPEED_W'(SPEED_MIN))
`ifdef INPUT_CMD_SATURATE_EN
      return SPEED_W'(SPEED_MIN);
`else
      return SPEED_W'(SPEED_MAX);
`endif
    return s - SPEED_W'(1);
  endfunction

  function automatic logic [3:0] moveOneHot(input logic [3:0] c);
    case (c)
      4'h7:    return 4'h1;
      4'h8:    return 4'h2;
      4'h9:    return 4'h4;
      4'hA:    return 4'h8;
      default: return 4'h0;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      userNum    <= 3'h4;
      movSpeed   <= SPEED_W'(SPEED_MIN);
      charRGB    <= '1;
      bgRGB      <= '0;
      charOffset <= '0;
      flashClk   <= 1'b1;
      cmdAck     <= 1'b0;
      targetBg   <= 1'b0;
      flashEn    <= 1'b0;
      flashCnt   <= '0;
      rptState   <= IDLE;
      rptCnt     <= '0;
      prevValid  <= 1'b0;
      prevCode   <= '0;
    end else begin
      // NOTE: pulse outputs get a non-blocking default first; a later assignment in this
      // same block overrides it, so they drop back to zero on every edge without an event.
      charOffset <= '0;
      cmdAck     <= 1'b0;
      prevValid  <= inValid;
      prevCode   <= inCode;

      if (flashEn) begin
        if (flashCnt == FLASH_W'(FLASH_DIV - 1)) begin
          flashCnt <= '0;
          flashClk <= ~flashClk;
        end else begin
          flashCnt <= flashCnt + FLASH_W'(1);
        end
      end else begin
        flashCnt <= '0;
        flashClk <= 1'b1;
      end

      if (press) begin
        rptState <= IDLE;
        rptCnt   <= '0;
        if (inRange) begin
          cmdAck <= 1'b1;
          case (op)
            4'h0, 4'h1, 4'h2, 4'h3: userNum <= op[2:0];
            4'h4: if (targetBg) bgRGB <= bumpRgb(bgRGB, 2); else charRGB <= bumpRgb(charRGB, 2);
            4'h5: if (targetBg) bgRGB <= bumpRgb(bgRGB, 1); else charRGB <= bumpRgb(charRGB, 1);
            4'h6: if (targetBg) bgRGB <= bumpRgb(bgRGB, 0); else charRGB <= bumpRgb(charRGB, 0);
            4'h7, 4'h8, 4'h9, 4'hA: begin
              charOffset <= moveOneHot(op);
              rptState   <= HOLD;
            end
            4'hB: movSpeed <= speedUp(movSpeed);
            4'hC: movSpeed <= speedDown(movSpeed);
            4'hD: targetBg <= ~targetBg;
            4'hE: begin
              // Either direction restarts the divider with the character shown.
              flashEn  <= ~flashEn;
              flashCnt <= '0;
              flashClk <= 1'b1;
            end
            default: begin
              charRGB  <= '1;
              bgRGB    <= '0;
              targetBg <= 1'b0;
            end
          endcase
        end
      end else if (!inValid) begin
        rptState <= IDLE;
        rptCnt   <= '0;
      end else begin
        case (rptState)
          HOLD: begin
            if (rptCnt == RPT_W'(REPEAT_DLY - 1)) begin
              rptState   <= REPEAT;
              rptCnt     <= '0;
              charOffset <= moveOneHot(op);
              cmdAck     <= 1'b1;
            end else begin
              rptCnt <= rptCnt + RPT_W'(1);
            end
          end
          REPEAT: begin
            if (rptCnt == RPT_W'(REPEAT_RATE - 1)) begin
              rptCnt     <= '0;
              charOffset <= moveOneHot(op);
              cmdAck     <= 1'b1;
            end else begin
              rptCnt <= rptCnt + RPT_W'(1);
            end
          end
          default: rptCnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_cmd_decoder.sv
// Directed self-checking bench for input_cmd_decoder at default parameters.
// Expectations follow INPUT_CMD_SATURATE_EN when the bench is built with it.
module tb_input_cmd_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] inCode;
  logic       inValid;
  logic [2:0] userNum;
  logic [3:0] movSpeed;
  logic [8:0] charRGB;
  logic [8:0] bgRGB;
  logic [3:0] charOffset;
  logic       flashClk;
  logic       cmdAck;

  int compared   = 0;
  int mismatched = 0;

  input_cmd_decoder dut (
    .clock      (clock),
    .reset      (reset),
    .inCode     (inCode),
    .inValid    (inValid),
    .userNum    (userNum),
    .movSpeed   (movSpeed),
    .charRGB    (charRGB),
    .bgRGB      (bgRGB),
    .charOffset (charOffset),
    .flashClk   (flashClk),
    .cmdAck     (cmdAck)
  );

  always #5 clock = ~clock;

  // Present inputs, let one rising edge consume them, then sample 1 ns later.
  task automatic step(input logic v, input logic [3:0] c);
    inValid = v;
    inCode  = c;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 4'hB);
    step(1'b0, 4'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, 4'h0);
    compared++; if (userNum !== 3'h4) begin mismatched++; $display("FAIL reset_userNum got=%h exp=4", userNum); end
    compared++; if (movSpeed !== 4'd1) begin mismatched++; $display("FAIL reset_movSpeed got=%h exp=1", movSpeed); end
    compared++; if (charRGB !== 9'h1FF) begin mismatched++; $display("FAIL reset_charRGB got=%h exp=1ff", charRGB); end
    compared++; if (bgRGB !== 9'h000) begin mismatched++; $display("FAIL reset_bgRGB got=%h exp=0", bgRGB); end
    compared++; if (flashClk !== 1'b1) begin mismatched++; $display("FAIL reset_flashClk got=%b exp=1", flashClk); end
    compared++; if ({charOffset, cmdAck} !== 5'b0) begin mismatched++; $display("FAIL reset_pulses got=%h/%b exp=0/0", charOffset, cmdAck); end
  endtask

  task automatic test_digit_speed();
    logic [3:0] spdExp [4];
    int acks;
`ifdef INPUT_CMD_SATURATE_EN
    spdExp = '{4'd2, 4'd3, 4'd4, 4'd4};
`else
    spdExp = '{4'd2, 4'd3, 4'd4, 4'd1};
`endif
    acks = 0;
    step(1'b1, 4'h2); acks += int'(cmdAck);
    compared++; if (userNum !== 3'h2) begin mismatched++; $display("FAIL digit_userNum got=%h exp=2", userNum); end
    step(1'b0, 4'h0); acks += int'(cmdAck);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'hB); acks += int'(cmdAck);
      compared++; if (movSpeed !== spdExp[k]) begin mismatched++; $display("FAIL speed_up_%0d got=%h exp=%h", k, movSpeed, spdExp[k]); end
      step(1'b0, 4'h0); acks += int'(cmdAck);
    end
    compared++; if (userNum !== 3'h2) begin mismatched++; $display("FAIL digit_hold got=%h exp=2", userNum); end
    compared++; if (acks !== 5) begin mismatched++; $display("FAIL digit_speed_acks got=%0d exp=5", acks); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s1, s2;
`ifdef INPUT_CMD_SATURATE_EN
    s1 = 4'd3; s2 = 4'd4;
`else
    s1 = 4'd4; s2 = 4'd1;
`endif
    step(1'b1, 4'hC);
    compared++; if ({movSpeed, cmdAck} !== {s1, 1'b1}) begin mismatched++; $display("FAIL b2b_down got=%h/%b exp=%h/1", movSpeed, cmdAck, s1); end
    step(1'b1, 4'hC);
    compared++; if ({movSpeed, cmdAck} !== {s1, 1'b0}) begin mismatched++; $display("FAIL b2b_held got=%h/%b exp=%h/0", movSpeed, cmdAck, s1); end
    step(1'b1, 4'hB);
    compared++; if ({movSpeed, cmdAck} !== {s2, 1'b1}) begin mismatched++; $display("FAIL b2b_change got=%h/%b exp=%h/1", movSpeed, cmdAck, s2); end
    step(1'b1, 4'h0);
    step(1'b1, 4'h3);
    compared++; if ({userNum, cmdAck} !== {3'h3, 1'b1}) begin mismatched++; $display("FAIL b2b_digit got=%h/%b exp=3/1", userNum, cmdAck); end
    step(1'b0, 4'h0);
  endtask

  task automatic test_colour();
    logic [8:0] rWrap, bWrap;
`ifdef INPUT_CMD_SATURATE_EN
    rWrap = 9'h1FF; bWrap = 9'h1FF;
`else
    rWrap = 9'h03F; bWrap = 9'h1F8;
`endif
    step(1'b1, 4'hD); step(1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin step(1'b1, 4'h4); step(1'b0, 4'h0); end
    compared++; if (bgRGB !== 9'h0C0) begin mismatched++; $display("FAIL colour_bg_red got=%h exp=0c0", bgRGB); end
    compared++; if (charRGB !== 9'h1FF) begin mismatched++; $display("FAIL colour_char_untouched got=%h exp=1ff", charRGB); end
    step(1'b1, 4'h5); step(1'b0, 4'h0);
    step(1'b1, 4'h6); step(1'b0, 4'h0);
    compared++; if (bgRGB !== 9'h0C9) begin mismatched++; $display("FAIL colour_bg_gb got=%h exp=0c9", bgRGB); end
    step(1'b1, 4'hD); step(1'b0, 4'h0);
    step(1'b1, 4'h4); step(1'b0, 4'h0);
    compared++; if (charRGB !== rWrap) begin mismatched++; $display("FAIL colour_char_red_top got=%h exp=%h", charRGB, rWrap); end
    step(1'b1, 4'hD); step(1'b0, 4'h0);
    step(1'b1, 4'hF); step(1'b0, 4'h0);
    compared++; if ({charRGB, bgRGB} !== {9'h1FF, 9'h000}) begin mismatched++; $display("FAIL colour_default got=%h/%h exp=1ff/000", charRGB, bgRGB); end
    step(1'b1, 4'h6); step(1'b0, 4'h0);
    compared++; if ({charRGB, bgRGB} !== {bWrap, 9'h000}) begin mismatched++; $display("FAIL colour_target_reset got=%h/%h exp=%h/000", charRGB, bgRGB, bWrap); end
    step(1'b1, 4'hF); step(1'b0, 4'h0);
  endtask

  task automatic test_repeat();
    logic [3:0] expOff;
    step(1'b1, 4'h9);
    compared++; if ({charOffset, cmdAck} !== {4'h4, 1'b1}) begin mismatched++; $display("FAIL repeat_press got=%h/%b exp=4/1", charOffset, cmdAck); end
    for (int i = 1; i < 30; i++) begin
      step(1'b1, 4'h9);
      expOff = (i == 16 || i == 20 || i == 24 || i == 28) ? 4'h4 : 4'h0;
      compared++; if ({charOffset, cmdAck} !== {expOff, expOff != 4'h0}) begin mismatched++; $display("FAIL repeat_hold_%0d got=%h/%b exp=%h", i, charOffset, cmdAck, expOff); end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'h0);
      compared++; if ({charOffset, cmdAck} !== 5'b0) begin mismatched++; $display("FAIL repeat_release_%0d got=%h/%b exp=0/0", i, charOffset, cmdAck); end
    end
    for (int i = 0; i < 18; i++) step(1'b1, 4'h7);
    step(1'b1, 4'hA);
    compared++; if ({charOffset, cmdAck} !== {4'h8, 1'b1}) begin mismatched++; $display("FAIL repeat_change got=%h/%b exp=8/1", charOffset, cmdAck); end
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 4'hA);
      expOff = (i == 16) ? 4'h8 : 4'h0;
      compared++; if (charOffset !== expOff) begin mismatched++; $display("FAIL repeat_restart_%0d got=%h exp=%h", i, charOffset, expOff); end
    end
    step(1'b0, 4'h0);
  endtask

  task automatic test_flash();
    logic expF;
    step(1'b1, 4'hE);
    compared++; if (flashClk !== 1'b1) begin mismatched++; $display("FAIL flash_enable got=%b exp=1", flashClk); end
    for (int k = 1; k <= 26; k++) begin
      step(1'b0, 4'h0);
      expF = ((k / 8) % 2) == 0;
      compared++; if (flashClk !== expF) begin mismatched++; $display("FAIL flash_k%0d got=%b exp=%b", k, flashClk, expF); end
    end
    step(1'b1, 4'hE);
    compared++; if ({flashClk, cmdAck} !== 2'b11) begin mismatched++; $display("FAIL flash_disable got=%b/%b exp=1/1", flashClk, cmdAck); end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'h0);
      compared++; if (flashClk !== 1'b1) begin mismatched++; $display("FAIL flash_off_%0d got=%b exp=1", k, flashClk); end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'h1); step(1'b0, 4'h0);
    step(1'b1, 4'hC); step(1'b0, 4'h0);
    step(1'b1, 4'hD); step(1'b0, 4'h0);
    step(1'b1, 4'h5); step(1'b0, 4'h0);
    step(1'b1, 4'hE); step(1'b0, 4'h0);
    for (int i = 0; i < 20; i++) step(1'b1, 4'h8);
    reset = 1'b1;
    step(1'b1, 4'h8);
    compared++; if ({userNum, movSpeed} !== {3'h4, 4'd1}) begin mismatched++; $display("FAIL rst_mid_num_speed got=%h/%h exp=4/1", userNum, movSpeed); end
    compared++; if ({charRGB, bgRGB} !== {9'h1FF, 9'h000}) begin mismatched++; $display("FAIL rst_mid_rgb got=%h/%h exp=1ff/000", charRGB, bgRGB); end
    compared++; if ({charOffset, cmdAck, flashClk} !== 6'b000001) begin mismatched++; $display("FAIL rst_mid_pulses got=%h/%b/%b exp=0/0/1", charOffset, cmdAck, flashClk); end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'h0);
      compared++; if ({charOffset, flashClk} !== 5'b00001) begin mismatched++; $display("FAIL rst_after_%0d got=%h/%b exp=0/1", i, charOffset, flashClk); end
    end
  endtask

  initial begin
    reset   = 1'b1;
    inValid = 1'b0;
    inCode  = 4'h0;
    test_reset();
    test_digit_speed();
    test_back_to_back();
    test_colour();
    test_repeat();
    test_flash();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
